// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART baud-rate reconfiguration sequencer.
// Divisor values assume a 50 MHz system clock.
package spart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    WR_LO,
    WR_HI,
    DONE,
    ERR
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_BAD_DIV = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_e;

  localparam logic [15:0] DIV_4800  = 16'd651;
  localparam logic [15:0] DIV_9600  = 16'd326;
  localparam logic [15:0] DIV_19200 = 16'd163;
  localparam logic [15:0] DIV_38400 = 16'd81;

  function automatic logic [15:0] preset_div(input logic [1:0] sel);
    logic [15:0] div;
    case (sel)
      2'd0:    div = DIV_4800;
      2'd1:    div = DIV_9600;
      2'd2:    div = DIV_19200;
      default: div = DIV_38400;
    endcase
    return div;
  endfunction

endpackage

// File: rtl/baud_cfg_ctrl_if.sv
// Bus-side request/response bundle for the baud reconfiguration sequencer.
// The master modport is the requester; the slave modport is the controller.
interface baud_cfg_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_raw;
  logic [1:0]  req_sel;
  logic [15:0] req_div;
  logic        cfg_done;
  logic        cfg_err;
  logic [1:0]  err_code;
  logic [15:0] cur_div;

  modport master (
    output req_valid, req_raw, req_sel, req_div,
    input  req_ready, cfg_done, cfg_err, err_code, cur_div
  );

  modport slave (
    input  req_valid, req_raw, req_sel, req_div,
    output req_ready, cfg_done, cfg_err, err_code, cur_div
  );
endinterface

// File: rtl/quiesce_timer.sv
// Saturating cycle counter bounding how long the sequencer waits for the UART to idle.
// tc_o flags the last permitted wait cycle, so the wait lasts exactly LIMIT cycles.
module quiesce_timer #(
  parameter int LIMIT = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] MaxCnt = W'(LIMIT);
  localparam logic [W-1:0] TcCnt  = W'(LIMIT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != MaxCnt))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q >= TcCnt);

endmodule

// File: rtl/baud_cfg_ctrl.sv
// Baud-rate reconfiguration sequencer: quiesces the UART, writes the divisor low/high
// byte to the generator and reports completion or error. Outputs decode from next state.
module baud_cfg_ctrl
  import spart_pkg::*;
#(
  parameter logic [15:0] MIN_DIV         = 16'd8,
  parameter int          QUIESCE_TIMEOUT = 1023,
  parameter logic [15:0] RESET_DIV       = 16'd326
) (
  input  logic                clk,
  input  logic                rst_n,
  baud_cfg_ctrl_if.slave      bus,
  input  logic                tx_busy,
  input  logic                rx_busy,
  output logic                tx_hold,
  output logic                baud_write_en,
  output logic                baud_write_location,
  output logic [7:0]          baud_generator_write_line
);

  state_e      state_q, state_d;
  err_e        err_sel;
  err_e        err_code_q, err_code_d;
  logic [15:0] tgt_div_q, tgt_div_d;
  logic [15:0] cur_div_q, cur_div_d;
  logic [7:0]  line_q, line_d;
  logic        tx_hold_q, tx_hold_d;
  logic        wr_en_q, wr_en_d;
  logic        wr_loc_q, wr_loc_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        timeout_hit;

  quiesce_timer #(
    .LIMIT(QUIESCE_TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (state_q != HOLD),
    .en_i  (state_q == HOLD),
    .tc_o  (timeout_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tgt_div_q  <= RESET_DIV;
      cur_div_q  <= RESET_DIV;
      err_code_q <= ERR_NONE;
      line_q     <= 8'd0;
      tx_hold_q  <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_loc_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_div_q  <= tgt_div_d;
      cur_div_q  <= cur_div_d;
      err_code_q <= err_code_d;
      line_q     <= line_d;
      tx_hold_q  <= tx_hold_d;
      wr_en_q    <= wr_en_d;
      wr_loc_q   <= wr_loc_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Busy inputs are only consulted in HOLD; once writing starts the sequence runs to DONE.
  always_comb begin
    state_d   = state_q;
    tgt_div_d = tgt_div_q;
    err_sel   = ERR_NONE;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          tgt_div_d = bus.req_raw ? bus.req_div : preset_div(bus.req_sel);
          if (bus.req_raw && (bus.req_div < MIN_DIV)) begin
            state_d = ERR;
            err_sel = ERR_BAD_DIV;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (!tx_busy && !rx_busy) begin
          state_d = WR_LO;
        end else if (timeout_hit) begin
          state_d = ERR;
          err_sel = ERR_TIMEOUT;
        end
      end
      WR_LO:   state_d = WR_HI;
      WR_HI:   state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_hold_d  = state_d inside {HOLD, WR_LO, WR_HI};
    wr_en_d    = state_d inside {WR_LO, WR_HI};
    wr_loc_d   = (state_d == WR_HI);
    done_d     = (state_d == DONE);
    err_d      = (state_d == ERR);
    err_code_d = err_sel;
    cur_div_d  = (state_d == DONE) ? tgt_div_q : cur_div_q;
    line_d     = 8'd0;
    if (state_d == WR_LO)
      line_d = tgt_div_d[7:0];
    else if (state_d == WR_HI)
      line_d = tgt_div_d[15:8];
  end

  assign bus.req_ready           = (state_q == IDLE);
  assign bus.cfg_done            = done_q;
  assign bus.cfg_err             = err_q;
  assign bus.err_code            = err_code_q;
  assign bus.cur_div             = cur_div_q;
  assign tx_hold                 = tx_hold_q;
  assign baud_write_en           = wr_en_q;
  assign baud_write_location     = wr_loc_q;
  assign baud_generator_write_line = line_q;

endmodule

// File: doc/baud_cfg_ctrl.md
Name: baud_cfg_ctrl

Overview:
- Reconfiguration sequencer for the SPART baud-rate generator.
- Accepts a baud-change request from the bus side, either a preset rate select or a raw 16-bit divisor.
- Holds off the transmitter, waits for TX and RX to go idle, then issues the two-byte divisor write (low byte, then high byte) on the generator's write port.
- Reports completion or error and keeps a shadow copy of the active divisor.

Parameters:
- MIN_DIV, 16'd8: smallest raw divisor accepted; anything below it is rejected.
- QUIESCE_TIMEOUT, 1023: maximum cycles spent in HOLD waiting for idle before aborting.
- RESET_DIV, 16'd326: divisor assumed after reset (50 MHz, 9600 bps); must match the generator's reset value.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request (high only in IDLE)
- req_raw  in  1  1 = use req_div; 0 = use req_sel preset
- req_sel  in  2  preset select: 0=4800, 1=9600, 2=19200, 3=38400
- req_div  in  16  raw divisor
- tx_busy  in  1  transmitter shifting a frame
- rx_busy  in  1  receiver mid-frame
- tx_hold  out  1  forbids the transmitter from starting a new frame
- baud_write_en  out  1  generator write strobe
- baud_write_location  out  1  0 = DB low byte, 1 = DB high byte
- baud_generator_write_line  out  8  divisor byte being written
- cfg_done  out  1  one-cycle pulse: new divisor installed
- cfg_err  out  1  one-cycle pulse: request rejected or aborted
- err_code  out  2  valid while cfg_err=1: 01 bad divisor, 10 quiesce timeout
- cur_div  out  16  shadow of the divisor the generator currently holds

Behaviour:
- Reset values:
  - State IDLE; req_ready=1.
  - tx_hold, baud_write_en, baud_write_location, cfg_done, cfg_err = 0.
  - baud_generator_write_line = 0; err_code = 00; cur_div = RESET_DIV.
- All outputs are registered except req_ready, which is decoded from state.
- Acceptance: on the edge where req_valid && req_ready, latch the target divisor into tgt_div.
  - Preset select resolves from the package table: 651, 326, 163, 81.
  - Raw path takes req_div.
- If req_raw=1 and req_div < MIN_DIV:
  - Go to ERR: cfg_err=1, err_code=01 for one cycle, then IDLE.
  - No generator writes; tx_hold never asserted.
- State machine: IDLE -> HOLD -> WR_LO -> WR_HI -> DONE -> IDLE, plus ERR -> IDLE.
  - HOLD:
    - tx_hold=1; timeout counter clears on entry and increments each cycle.
    - If tx_busy=0 and rx_busy=0 in a cycle, next state is WR_LO.
    - Otherwise, if the counter reaches QUIESCE_TIMEOUT, go to ERR with err_code=10 and release tx_hold.
  - WR_LO: baud_write_en=1, baud_write_location=0, line=tgt_div[7:0]; tx_hold stays 1.
  - WR_HI: baud_write_en=1, baud_write_location=1, line=tgt_div[15:8]; tx_hold stays 1.
  - DONE: cfg_done=1, cur_div<=tgt_div, tx_hold=0, baud_write_en=0.
- Best-case latency with the UART already idle:
  - Accept on edge N; HOLD in cycle N+1.
  - WR_LO in N+2; WR_HI in N+3; DONE pulse in N+4; req_ready=1 again in N+5.
- Writes are always back-to-back, low then high, and never interleaved with another request.
- The generator suspends counting during the two write cycles. The new rate takes effect at its next counter reload, which is acceptable because TX and RX are quiescent.
- While not in IDLE, req_valid is ignored; the requester must hold req_valid until req_ready.
- A busy input rising during WR_LO/WR_HI is ignored. Blocking new frames is the job of tx_hold; rx_busy rising is a line glitch and is not guarded.
- Same-divisor request: still performs the full sequence and pulses cfg_done.
- Reset asserted mid-sequence:
  - Everything returns to reset values immediately.
  - The generator shares rst_n, so no half-written divisor survives; cur_div=RESET_DIV stays consistent.
- The timeout counter saturates and never wraps. Its width is $clog2(QUIESCE_TIMEOUT+1).

Decomposition:
- spart_pkg holds:
  - typedef enum for the states: IDLE, HOLD, WR_LO, WR_HI, DONE, ERR.
  - Divisor constants DIV_4800=651, DIV_9600=326, DIV_19200=163, DIV_38400=81.
  - A 4-entry preset lookup function.
  - Error codes ERR_NONE, ERR_BAD_DIV, ERR_TIMEOUT.
- One sub-module: quiesce_timer, a saturating counter with clear/enable and a terminal-count flag, used in HOLD.

Test Plan:
- Reset, then idle 10 cycles: req_ready=1, cur_div=326, all strobes 0, baud_write_line=0.
- Preset req_sel=2, UART idle, accept at N: write (loc0, 0xA3) at N+2, (loc1, 0x00) at N+3, cfg_done at N+4, cur_div=163, tx_hold high N+1..N+3.
- Raw req_div=0x1234 with tx_busy=1 for 5 cycles after accept: no write until tx_busy falls; then 0x34 low, 0x12 high on consecutive cycles; cfg_done follows.
- Raw req_div=5: cfg_err pulse with err_code=01 one cycle after accept, no baud_write_en, tx_hold never high, cur_div unchanged.
- rx_busy stuck high: cfg_err with err_code=10 after QUIESCE_TIMEOUT HOLD cycles, tx_hold drops the same cycle, no writes; a second request is then accepted normally.
- Reset asserted during WR_HI: all outputs at reset values next cycle; cur_div=326. A held req_valid is not accepted while busy, then is accepted once IDLE.
